prog_loader: RTL

Boot-time program loader that sits directly upstream of the processor core and its instruction memory. It accepts a valid/ready stream of instruction words, writes them into instruction memory starting at address 0, and holds the core in reset until loading completes. It then hands the instruction-memory address port to the core and reports halt. The bench-side direct drive of the memory write port (`inst_write` / `inst_in`) is replaced by this block.

---
 rtl/prog_loader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_loader: streams a program into instruction memory, then releases the  |
// | core and hands it the memory address port.  Revision: 1.0                  |
// +----------------------------------------------------------------------------+
module prog_loader #(
  parameter int WORD = 32,
  parameter int ADDR = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [WORD-1:0] data_i,
  input  logic            valid_i,
  input  logic            last_i,
  output logic            ready_o,
  input  logic [ADDR-1:0] core_addr_i,
  input  logic            hlt_i,
  output logic [ADDR-1:0] mem_addr_o,
  output logic            mem_write_o,
  output logic [WORD-1:0] mem_data_o,
  output logic            core_reset_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            ovf_o,
  output logic [ADDR:0]   count_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_HALT = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [ADDR-1:0] PTR_ONE  = {{(ADDR-1){1'b0}}, 1'b1};
  localparam logic [ADDR-1:0] PTR_LAST = {ADDR{1'b1}};
  localparam logic [ADDR:0]   CNT_ONE  = {{ADDR{1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR:0]   count_q, count_d;
  logic            hs;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    ready_o      = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = wr_ptr_q;
    mem_data_o   = data_i;
    core_reset_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    ovf_o        = 1'b0;
    hs           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          wr_ptr_d = '0;
          count_d  = '0;
          state_d  = S_LOAD;
        end
      end

      S_LOAD: begin
        busy_o = 1'b1;
        // Reset wins over a handshake on the same edge, so the memory must not see a write.
        ready_o     = reset;
        hs          = valid_i & reset;
        mem_write_o = hs;
        if (hs) begin
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          count_d  = count_q + CNT_ONE;
          if (last_i) begin
            state_d = S_RUN;
          end else if (wr_ptr_q == PTR_LAST) begin
            state_d = S_ERR;
          end
        end
      end

      S_RUN: begin
        core_reset_o = 1'b1;
        mem_addr_o   = core_addr_i;
        if (hlt_i) begin
          state_d = S_HALT;
        end
      end

      S_HALT: begin
        // Core stays alive on the address port so its state can be dumped.
        core_reset_o = 1'b1;
        mem_addr_o   = core_addr_i;
        done_o       = 1'b1;
        if (start_i) begin
          wr_ptr_d = '0;
          count_d  = '0;
          state_d  = S_LOAD;
        end
      end

      S_ERR: begin
        ovf_o = 1'b1;
        if (start_i) begin
          wr_ptr_d = '0;
          count_d  = '0;
          state_d  = S_LOAD;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign count_o = count_q;

endmodule
`default_nettype wire
